// File: rtl/display_scan_ctrl_pkg.sv
// Types and helpers shared by the seven-segment scan controller and its digit splitter.
package display_scan_ctrl_pkg;
`include "display_defs.vh"

  typedef enum logic [1:0] {
    SEL_D0 = 2'd0,
    SEL_D1 = 2'd1,
    SEL_D2 = 2'd2,
    SEL_D3 = 2'd3
  } sel_e;

  function automatic logic [3:0] an_for_sel(input sel_e s);
    logic [3:0] p;
    case (s)
      SEL_D3:  p = AN_D3;
      SEL_D2:  p = AN_D2;
      SEL_D1:  p = AN_D1;
      default: p = AN_D0;
    endcase
    return p;
  endfunction

  // Slots 3 and 2 belong to the left field, 1 and 0 to the right field.
  function automatic logic is_left(input sel_e s);
    return (s == SEL_D3) || (s == SEL_D2);
  endfunction

endpackage

// File: rtl/display_defs.vh
// Shared display encodings: blank BCD code, anode patterns per digit slot, largest showable field.
localparam logic [3:0] BLANK_CODE = 4'hF;
localparam logic [3:0] AN_OFF     = 4'b1111;
localparam logic [3:0] AN_D3      = 4'b0111;
localparam logic [3:0] AN_D2      = 4'b1011;
localparam logic [3:0] AN_D1      = 4'b1101;
localparam logic [3:0] AN_D0      = 4'b1110;
localparam logic [7:0] MAX_FIELD  = 8'd99;

// File: rtl/display_scan_ctrl_split_output.sv
// Splits a binary field 0..99 into BCD tens/ones; out-of-range values blank both digits.
module split_output
  import display_scan_ctrl_pkg::*;
(
  input  logic [7:0] total,
  output logic [3:0] left,
  output logic [3:0] right
);

  always_comb begin
    left  = 4'(total / 8'd10);
    right = 4'(total % 8'd10);
    if (total > MAX_FIELD) begin
      left  = BLANK_CODE;
      right = BLANK_CODE;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scanner for two 8-bit fields, frame-consistent snapshots, guard band and blink.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] left_val,
  input  logic [7:0] right_val,
  input  logic [1:0] blink_en,
  input  logic       blink_tick,
  input  logic       dp_en,
  output logic [3:0] an,
  output logic [3:0] digit,
  output logic       dp
);

  localparam int            CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;
  sel_e          sel;
  logic          phase;
  logic [7:0]    left_snap;
  logic [7:0]    right_snap;

  logic [7:0]    split_in;
  logic [3:0]    tens;
  logic [3:0]    ones;
  logic [3:0]    slot_digit;
  logic          terminal;
  logic          in_guard;
  logic          blanked;

  always_comb begin
    split_in   = is_left(sel) ? left_snap : right_snap;
    slot_digit = ((sel == SEL_D3) || (sel == SEL_D1)) ? tens : ones;
    terminal   = (cnt == CNT_LAST);
    in_guard   = int'(cnt) < GUARD;
    blanked    = phase & (is_left(sel) ? blink_en[1] : blink_en[0]);
  end

  split_output u_split (
    .total (split_in),
    .left  (tens),
    .right (ones)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      sel        <= SEL_D3;
      phase      <= 1'b0;
      left_snap  <= '0;
      right_snap <= '0;
      an         <= AN_OFF;
      digit      <= BLANK_CODE;
      dp         <= 1'b1;
    end else begin
      if (terminal) begin
        cnt <= '0;
        sel <= sel_e'(sel - 2'd1);
        // Latch on the last cycle of slot 0 so the whole next frame sees one pair of values.
        if (sel == SEL_D0) begin
          left_snap  <= left_val;
          right_snap <= right_val;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (blink_tick) begin
        phase <= ~phase;
      end

      digit <= slot_digit;
      an    <= (in_guard || blanked) ? AN_OFF : an_for_sel(sel);
      dp    <= ~(dp_en && (sel == SEL_D2) && !in_guard && !blanked);
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Frame-level scoreboard bench for display_scan_ctrl with a short refresh divider.
module tb_display_scan_ctrl;

  localparam int REFRESH_DIV = 4;
  localparam int GUARD       = 1;
  localparam int NVEC        = 12;

  logic       clk;
  logic       rst_n = 1'b1;
  logic [7:0] left_val;
  logic [7:0] right_val;
  logic [1:0] blink_en;
  logic       blink_tick;
  logic       dp_en;
  logic [3:0] an;
  logic [3:0] digit;
  logic       dp;

  display_scan_ctrl #(
    .REFRESH_DIV (REFRESH_DIV),
    .GUARD       (GUARD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .left_val   (left_val),
    .right_val  (right_val),
    .blink_en   (blink_en),
    .blink_tick (blink_tick),
    .dp_en      (dp_en),
    .an         (an),
    .digit      (digit),
    .dp         (dp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] l;
    logic [7:0] r;
    logic       dpe;
    logic [1:0] ben;
    logic       tick;
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [3:0] digit;
    logic       dp;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic chk_on = 1'b0;
  logic ph = 1'b0;

  // Builds the 16 expected output cycles of one frame from the slot digits and live controls.
  task automatic push_frame(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                            input logic [3:0] d0, input logic dpe, input logic [1:0] ben,
                            input logic phs);
    logic [3:0] dg [4];
    dg[3] = d3; dg[2] = d2; dg[1] = d1; dg[0] = d0;
    for (int s = 3; s >= 0; s--) begin
      for (int c = 0; c < REFRESH_DIV; c++) begin
        exp_t e;
        logic guard;
        logic blank;
        logic [3:0] pat;
        guard  = (c < GUARD);
        blank  = phs && ((s >= 2) ? ben[1] : ben[0]);
        pat    = 4'b1111;
        pat[s] = 1'b0;
        e.an    = (guard || blank) ? 4'b1111 : pat;
        e.digit = dg[s];
        e.dp    = (dpe && s == 2 && !guard && !blank) ? 1'b0 : 1'b1;
        exp_q.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (chk_on && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (an !== e.an || digit !== e.digit || dp !== e.dp) begin
        n_err++;
        $display("FAIL scan @%0t: an=%b digit=%h dp=%b, expected an=%b digit=%h dp=%b",
                 $time, an, digit, dp, e.an, e.digit, e.dp);
      end
    end
  end

  task automatic chk_blank(input string name);
    n_vec++;
    if (an !== 4'b1111 || digit !== 4'hF || dp !== 1'b1) begin
      n_err++;
      $display("FAIL %s: an=%b digit=%h dp=%b, expected an=1111 digit=f dp=1",
               name, an, digit, dp);
    end
  endtask

  // Starts at the first output cycle of a frame; inputs latch for the next frame, controls
  // switch exactly at the frame boundary and the tick lands on the terminal-count edge.
  task automatic run_frame(input vec_t v, input logic phs);
    left_val  = v.l;
    right_val = v.r;
    push_frame(v.d3, v.d2, v.d1, v.d0, v.dpe, v.ben, phs);
    repeat (14) @(negedge clk);
    blink_tick = v.tick;
    @(negedge clk);
    blink_tick = 1'b0;
    dp_en      = v.dpe;
    blink_en   = v.ben;
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{8'd12,  8'd34, 1'b1, 2'b00, 1'b0, 4'd1, 4'd2, 4'd3, 4'd4};
    vecs[1]  = '{8'd12,  8'd59, 1'b1, 2'b00, 1'b0, 4'd1, 4'd2, 4'd5, 4'd9};
    vecs[2]  = '{8'd120, 8'd59, 1'b1, 2'b00, 1'b0, 4'hF, 4'hF, 4'd5, 4'd9};
    vecs[3]  = '{8'd99,  8'd0,  1'b1, 2'b00, 1'b0, 4'd9, 4'd9, 4'd0, 4'd0};
    vecs[4]  = '{8'd100, 8'd99, 1'b1, 2'b00, 1'b0, 4'hF, 4'hF, 4'd9, 4'd9};
    vecs[5]  = '{8'd12,  8'd34, 1'b1, 2'b10, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4};
    vecs[6]  = '{8'd12,  8'd34, 1'b1, 2'b10, 1'b0, 4'd1, 4'd2, 4'd3, 4'd4};
    vecs[7]  = '{8'd12,  8'd34, 1'b1, 2'b10, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4};
    vecs[8]  = '{8'd56,  8'd78, 1'b1, 2'b01, 1'b1, 4'd5, 4'd6, 4'd7, 4'd8};
    vecs[9]  = '{8'd56,  8'd78, 1'b0, 2'b00, 1'b0, 4'd5, 4'd6, 4'd7, 4'd8};
    vecs[10] = '{8'd255, 8'd7,  1'b1, 2'b11, 1'b1, 4'hF, 4'hF, 4'd0, 4'd7};
    vecs[11] = '{8'd0,   8'd10, 1'b1, 2'b11, 1'b1, 4'd0, 4'd0, 4'd1, 4'd0};

    left_val   = 8'd0;
    right_val  = 8'd0;
    blink_en   = 2'b00;
    blink_tick = 1'b0;
    dp_en      = 1'b1;

    #2 rst_n = 1'b0;
    #1 chk_blank("async_reset");
    repeat (3) @(posedge clk);
    #1 chk_blank("reset_held");

    @(negedge clk);
    rst_n = 1'b1;
    ph    = 1'b0;
    push_frame(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 2'b00, 1'b0);
    @(negedge clk);
    chk_on = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      ph = ph ^ vecs[i].tick;
      run_frame(vecs[i], ph);
    end

    // Reset while slot 1 is actively lit; phase must also return to 0.
    repeat (9) @(negedge clk);
    chk_on = 1'b0;
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1 chk_blank("reset_midframe");
    @(posedge clk);
    @(posedge clk);
    #1 chk_blank("reset_midframe_held");
    @(negedge clk);
    dp_en    = 1'b1;
    blink_en = 2'b11;
    rst_n    = 1'b1;
    ph       = 1'b0;
    push_frame(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 2'b11, 1'b0);
    @(negedge clk);
    chk_on = 1'b1;
    run_frame('{8'd12, 8'd34, 1'b1, 2'b11, 1'b0, 4'd1, 4'd2, 4'd3, 4'd4}, 1'b0);
    repeat (16) @(negedge clk);
    #3;
    chk_on = 1'b0;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected cycles left unchecked, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
